// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter that shares one memory controller between a fetch port (0) and a data port (1).
// It latches the winning request, pulses the controller enable, and returns read data with a done pulse.
module mem_access_arbiter #(
   parameter  int WORD = 16,
   localparam int AW   = WORD - (WORD / 8) + 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            req0_i,
   input  logic            req1_i,
   input  logic            rw0_i,
   input  logic            rw1_i,
   input  logic [1:0]      sel0_i,
   input  logic [1:0]      sel1_i,
   input  logic [AW-1:0]   addr0_i,
   input  logic [AW-1:0]   addr1_i,
   input  logic [WORD-1:0] wdata0_i,
   input  logic [WORD-1:0] wdata1_i,
   output logic            gnt0_o,
   output logic            gnt1_o,
   output logic            done0_o,
   output logic            done1_o,
   output logic [WORD-1:0] rdata0_o,
   output logic [WORD-1:0] rdata1_o,
   output logic            ctl_en_o,
   output logic            ctl_rw_o,
   output logic [1:0]      ctl_sel_o,
   output logic [AW-1:0]   ctl_addr_o,
   output logic [WORD-1:0] ctl_data_o,
   input  logic            ctl_busy_i,
   input  logic [WORD-1:0] ctl_data_i
);

   // state  | meaning
   // IDLE   | no transaction; arbitrate between pending requests
   // LAUNCH | ctl_en_o pulses for one cycle with the latched request
   // WAIT   | controller busy; read data shadowed each busy cycle
   // RESP   | done pulse to the owner; read data published
   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

   state_t          state_q, state_d;
   logic            last_grant_q, last_grant_d;
   logic            gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic            done0_q, done0_d, done1_q, done1_d;
   logic            ctl_en_q, ctl_en_d;
   logic            ctl_rw_q, ctl_rw_d;
   logic [1:0]      ctl_sel_q, ctl_sel_d;
   logic [AW-1:0]   ctl_addr_q, ctl_addr_d;
   logic [WORD-1:0] ctl_data_q, ctl_data_d;
   logic [WORD-1:0] shadow_q, shadow_d;
   logic [WORD-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic            pick1;

   // Port 1 wins when it is the only requester, or on a tie when port 0 was served last.
   assign pick1 = req1_i & (~req0_i | ~last_grant_q);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      gnt0_d       = gnt0_q;
      gnt1_d       = gnt1_q;
      done0_d      = 1'b0;
      done1_d      = 1'b0;
      ctl_en_d     = 1'b0;
      ctl_rw_d     = ctl_rw_q;
      ctl_sel_d    = ctl_sel_q;
      ctl_addr_d   = ctl_addr_q;
      ctl_data_d   = ctl_data_q;
      shadow_d     = shadow_q;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      case (state_q)
         S_IDLE: begin
            if (req0_i | req1_i) begin
               ctl_rw_d     = pick1 ? rw1_i    : rw0_i;
               ctl_sel_d    = pick1 ? sel1_i   : sel0_i;
               ctl_addr_d   = pick1 ? addr1_i  : addr0_i;
               ctl_data_d   = pick1 ? wdata1_i : wdata0_i;
               last_grant_d = pick1;
               gnt0_d       = ~pick1;
               gnt1_d       = pick1;
               ctl_en_d     = 1'b1;
               state_d      = S_LAUNCH;
            end
         end
         S_LAUNCH: state_d = S_WAIT;
         S_WAIT: begin
            if (ctl_busy_i && !ctl_rw_q) shadow_d = ctl_data_i;
            if (!ctl_busy_i) begin
               done0_d = gnt0_q;
               done1_d = gnt1_q;
               if (!ctl_rw_q) begin
                  if (gnt0_q) rdata0_d = shadow_q;
                  if (gnt1_q) rdata1_d = shadow_q;
               end
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         gnt0_q       <= 1'b0;
         gnt1_q       <= 1'b0;
         done0_q      <= 1'b0;
         done1_q      <= 1'b0;
         ctl_en_q     <= 1'b0;
         ctl_rw_q     <= 1'b0;
         ctl_sel_q    <= '0;
         ctl_addr_q   <= '0;
         ctl_data_q   <= '0;
         shadow_q     <= '0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         gnt0_q       <= gnt0_d;
         gnt1_q       <= gnt1_d;
         done0_q      <= done0_d;
         done1_q      <= done1_d;
         ctl_en_q     <= ctl_en_d;
         ctl_rw_q     <= ctl_rw_d;
         ctl_sel_q    <= ctl_sel_d;
         ctl_addr_q   <= ctl_addr_d;
         ctl_data_q   <= ctl_data_d;
         shadow_q     <= shadow_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   assign gnt0_o     = gnt0_q;
   assign gnt1_o     = gnt1_q;
   assign done0_o    = done0_q;
   assign done1_o    = done1_q;
   assign rdata0_o   = rdata0_q;
   assign rdata1_o   = rdata1_q;
   assign ctl_en_o   = ctl_en_q;
   assign ctl_rw_o   = ctl_rw_q;
   assign ctl_sel_o  = ctl_sel_q;
   assign ctl_addr_o = ctl_addr_q;
   assign ctl_data_o = ctl_data_q;

endmodule
